multiplicador_seq8: RTL and testbench

Sequential 8x8 unsigned shift-and-add multiplier controller.
- Time-multiplexes a single `somador8bits` instance (the existing 8-bit ripple adder) over eight add/shift steps to form a 16-bit product.
- Sits between a requesting unit (start/operands) and the shared adder datapath.
- Trades latency for area: one adder, no array multiplier.

---
 rtl/multiplicador_seq8.sv | 133 +++++++++++++
 tb/tb_multiplicador_seq8.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq8.sv
// Sequential 8x8 unsigned shift-and-add multiplier built around one 8-bit ripple adder.

// 8-bit ripple-carry adder shared by the multiplier datapath.
module somador8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] carry;

  // Bit-serial carry chain, LSB first.
  always_comb begin
    carry    = 9'h000;
    sum      = 8'h00;
    carry[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    cout = carry[8];
  end

endmodule

module multiplicador_seq8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          busy_next;
  logic          done_next;

  logic [W-1:0]  m;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [CW-1:0] cnt;

  logic [W-1:0]  add_b;
  logic [W-1:0]  sum;
  logic          cout;

  // Multiplicand is added only when the current multiplier LSB is set.
  assign add_b = lo[0] ? m : W'(0);

  somador8bits u_add (
    .a    (hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // State register plus registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state decode; flags follow the state being entered.
  always_comb begin
    state_next = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == CW'(7)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == CALC);
    done_next = (state_next == DONE);
  end

  // Operand capture, shift-add steps and product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      m   <= '0;
      hi  <= '0;
      lo  <= '0;
      cnt <= '0;
      p   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            hi  <= '0;
            lo  <= b;
            cnt <= '0;
          end
        end
        CALC: begin
          hi  <= {cout, sum[W-1:1]};
          lo  <= {sum[0], lo[W-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(7)) begin
            p <= PW'({cout, sum, lo[W-1:1]});
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq8.sv
// Directed self-checking bench for multiplicador_seq8.
`timescale 1ns/1ps

module tb_multiplicador_seq8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [15:0] last_p;

  multiplicador_seq8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    step();
    step();
    n_checks++;
    if ({busy, done, p} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL reset: busy=%b done=%b p=%h, want 0 0 0000", busy, done, p);
    else n_pass++;
    rst = 1'b0;
    last_p = 16'h0000;
  endtask

  task automatic test_idle();
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i * 7); b = 8'(i * 13);
      step();
      if (busy !== 1'b0 || done !== 1'b0 || p !== 16'h0000) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL idle: outputs moved without start (busy=%b done=%b p=%h)", busy, done, p);
    else n_pass++;
  endtask

  // Start in cycle 0; expect busy 1-8, done 9 with product, idle in 10.
  task automatic test_product(input logic [7:0] va, input logic [7:0] vb,
                              input logic [15:0] exp_p, input string tag);
    logic bad;
    bad = 1'b0;
    start = 1'b1; a = va; b = vb;
    for (int k = 1; k <= 8; k++) begin
      step();
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0 || p !== last_p) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL %s calc: busy=%b done=%b p=%h, want 1 0 %h", tag, busy, done, p, last_p);
    else n_pass++;
    step();
    n_checks++;
    if ({busy, done, p} !== {1'b0, 1'b1, exp_p})
      $display("FAIL %s done: busy=%b done=%b p=%h, want 0 1 %h", tag, busy, done, p, exp_p);
    else n_pass++;
    last_p = exp_p;
    step();
    n_checks++;
    if ({busy, done} !== 2'b00)
      $display("FAIL %s idle: busy=%b done=%b, want 0 0", tag, busy, done);
    else n_pass++;
  endtask

  task automatic test_basic();
    test_product(8'd13,  8'd11,  16'h008F, "p13x11");
    test_product(8'h00,  8'hFF,  16'h0000, "p00xFF");
    test_product(8'hFF,  8'hFF,  16'hFE01, "pFFxFF");
    test_product(8'h80,  8'h02,  16'h0100, "p80x02");
  endtask

  task automatic test_ignored_start();
    logic bad;
    int   n_done;
    bad = 1'b0; n_done = 0;
    start = 1'b1; a = 8'd3; b = 8'd5;
    for (int k = 1; k <= 11; k++) begin
      step();
      start = (k == 3 || k == 9);
      a = (k == 3 || k == 9) ? 8'd9 : 8'(k * 31);
      b = (k == 3 || k == 9) ? 8'd9 : 8'(k * 17 + 1);
      if (done === 1'b1) n_done++;
      if (k <= 8 && (busy !== 1'b1 || done !== 1'b0)) bad = 1'b1;
      if (k == 9 && (done !== 1'b1 || p !== 16'h000F)) bad = 1'b1;
      if (k >= 10 && (busy !== 1'b0 || done !== 1'b0)) bad = 1'b1;
    end
    start = 1'b0;
    n_checks++;
    if (bad || n_done != 1)
      $display("FAIL ignored_start: done pulses=%0d p=%h busy=%b, want 1 000f 0", n_done, p, busy);
    else n_pass++;
    n_checks++;
    if (p !== 16'h000F) $display("FAIL ignored_start_p: p=%h, want 000f", p);
    else n_pass++;
    last_p = 16'h000F;
  endtask

  task automatic test_back_to_back();
    test_product(8'd7,   8'd6,   16'h002A, "b2b_first");
    test_product(8'd200, 8'd100, 16'h4E20, "b2b_second");
  endtask

  task automatic test_reset_mid();
    logic bad;
    bad = 1'b0;
    start = 1'b1; a = 8'hAA; b = 8'h55;
    for (int k = 1; k <= 5; k++) begin
      step();
      start = 1'b0;
      if (done !== 1'b0) bad = 1'b1;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (bad || {busy, done, p} !== {1'b0, 1'b0, 16'h0000})
      $display("FAIL reset_mid: busy=%b done=%b p=%h, want 0 0 0000", busy, done, p);
    else n_pass++;
    last_p = 16'h0000;
    step();
    test_product(8'd2, 8'd3, 16'h0006, "after_reset");
  endtask

  // Strided operand sweep run back-to-back against a*b.
  task automatic test_sweep();
    logic [7:0]  va, vb;
    logic [15:0] exp_p;
    int unsigned n_bad, n_overlap;
    n_bad = 0; n_overlap = 0;
    for (int i = 0; i < 600; i++) begin
      va = (i < 16) ? ((i < 8) ? 8'h00 : 8'hFF) : 8'(i * 37 + 5);
      vb = (i < 16) ? 8'(i * 37) : 8'(i * 91 + (i >> 3));
      exp_p = 16'(va) * 16'(vb);
      start = 1'b1; a = va; b = vb;
      for (int k = 1; k <= 10; k++) begin
        step();
        start = 1'b0;
        if (busy === 1'b1 && done === 1'b1) n_overlap++;
        if (k == 9 && (done !== 1'b1 || p !== exp_p)) begin
          n_bad++;
          if (n_bad <= 5)
            $display("FAIL sweep %0d: a=%h b=%h done=%b p=%h, want %h", i, va, vb, done, p, exp_p);
        end
      end
    end
    n_checks++;
    if (n_bad != 0) $display("FAIL sweep: %0d wrong products, want 0", n_bad);
    else n_pass++;
    n_checks++;
    if (n_overlap != 0) $display("FAIL overlap: %0d cycles busy&done, want 0", n_overlap);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    last_p   = 16'h0000;
    test_reset();
    test_idle();
    test_basic();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
